// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_pkg;

    typedef enum logic [1:0] {
        S_FETCH,
        S_HOLD,
        S_DRAIN
    } state_t;

    localparam logic [31:0] INST_NOP = 32'h0000_0013;
    localparam int          PC_STEP  = 4;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: bubble beats load, otherwise holds.
// Latency 1 cycle; holding is the only backpressure response.
module if_id_reg
    import if_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            bubble,
    input  logic [XLEN-1:0] load_pc,
    input  logic [31:0]     load_inst,
    output logic [XLEN-1:0] pc,
    output logic [31:0]     inst,
    output logic            valid
);

    always_ff @(posedge clk) begin
        if (rst || bubble) begin
            pc    <= '0;
            inst  <= INST_NOP;
            valid <= 1'b0;
        end else if (load) begin
            pc    <= load_pc;
            inst  <= load_inst;
            valid <= 1'b1;
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Fetch PC generation with a single-outstanding imem handshake feeding IF/ID.
// Latency: instruction reaches ID the cycle after its ack; a stalled ack parks in a skid slot.
module if_fetch_unit
    import if_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            PC_EN_IF,
    input  logic            reg_FD_stall,
    input  logic            reg_FD_flush,
    input  logic [XLEN-1:0] redirect_target_ID,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic [XLEN-1:0] pc_ID,
    output logic [31:0]     inst_ID,
    output logic            valid_ID,
    output logic            fetch_busy
);

    localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(PC_STEP - 1));

    state_t          state, state_nxt;
    logic [XLEN-1:0] req_pc, req_pc_nxt;
    logic [XLEN-1:0] pending_pc, pending_pc_nxt;
    logic [XLEN-1:0] skid_pc, skid_pc_nxt;
    logic [31:0]     skid_inst, skid_inst_nxt;
    logic            req_q;

    logic            advance, redirect, done;
    logic [XLEN-1:0] target, pc_inc;
    logic            id_load, id_bubble;
    logic [XLEN-1:0] id_pc;
    logic [31:0]     id_inst;

    assign advance  = PC_EN_IF & ~reg_FD_stall;
    assign redirect = reg_FD_flush & ~reg_FD_stall;
    assign done     = req_q & imem_ack;
    assign target   = redirect_target_ID & ALIGN_MASK;
    assign pc_inc   = req_pc + XLEN'(PC_STEP);

    always_comb begin
        state_nxt      = state;
        req_pc_nxt     = req_pc;
        pending_pc_nxt = pending_pc;
        skid_pc_nxt    = skid_pc;
        skid_inst_nxt  = skid_inst;
        id_load        = 1'b0;
        id_bubble      = 1'b0;
        id_pc          = req_pc;
        id_inst        = imem_rdata;

        unique case (state)
            S_FETCH: begin
                if (redirect) begin
                    id_bubble = 1'b1;
                    // An unanswered request cannot be withdrawn, so drain it first.
                    if (req_q && !imem_ack) begin
                        state_nxt      = S_DRAIN;
                        pending_pc_nxt = target;
                    end else begin
                        req_pc_nxt = target;
                    end
                end else if (done) begin
                    req_pc_nxt = pc_inc;
                    if (advance) begin
                        id_load = 1'b1;
                    end else begin
                        skid_pc_nxt   = req_pc;
                        skid_inst_nxt = imem_rdata;
                        state_nxt     = S_HOLD;
                    end
                end else if (advance) begin
                    id_bubble = 1'b1;
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    id_bubble  = 1'b1;
                    req_pc_nxt = target;
                    state_nxt  = S_FETCH;
                end else if (advance) begin
                    id_load   = 1'b1;
                    id_pc     = skid_pc;
                    id_inst   = skid_inst;
                    state_nxt = S_FETCH;
                end
            end
            S_DRAIN: begin
                if (redirect) begin
                    pending_pc_nxt = target;
                end
                if (redirect || advance) begin
                    id_bubble = 1'b1;
                end
                if (done) begin
                    req_pc_nxt = redirect ? target : pending_pc;
                    state_nxt  = S_FETCH;
                end
            end
            default: begin
                state_nxt = S_FETCH;
            end
        endcase
    end

    // Request is registered, so the cycle right after reset is idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_FETCH;
            req_q      <= 1'b0;
            req_pc     <= RESET_PC & ALIGN_MASK;
            pending_pc <= '0;
            skid_pc    <= '0;
            skid_inst  <= INST_NOP;
        end else begin
            state      <= state_nxt;
            req_q      <= (state_nxt != S_HOLD);
            req_pc     <= req_pc_nxt;
            pending_pc <= pending_pc_nxt;
            skid_pc    <= skid_pc_nxt;
            skid_inst  <= skid_inst_nxt;
        end
    end

    assign imem_req   = req_q;
    assign imem_addr  = req_pc;
    assign fetch_busy = (state != S_FETCH);

    if_id_reg #(.XLEN(XLEN)) u_if_id_reg (
        .clk       (clk),
        .rst       (rst),
        .load      (id_load),
        .bubble    (id_bubble),
        .load_pc   (id_pc),
        .load_inst (id_inst),
        .pc        (pc_ID),
        .inst      (inst_ID),
        .valid     (valid_ID)
    );

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: program-order scoreboard plus directed timing checks.
module tb_if_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0200;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        PC_EN_IF = 1'b1;
    logic        reg_FD_stall = 1'b0;
    logic        reg_FD_flush = 1'b0;
    logic [31:0] redirect_target_ID = 32'h0;
    logic        imem_req, imem_ack;
    logic [31:0] imem_addr, imem_rdata;
    logic [31:0] pc_ID, inst_ID;
    logic        valid_ID, fetch_busy;

    int tests = 0;
    int fails = 0;
    int consumed = 0;

    int unsigned wmin = 0;
    int unsigned wmax = 0;
    logic [1:0]  wcnt = 2'd0;

    logic [31:0] redir_q[$];

    if_fetch_unit #(.XLEN(32), .RESET_PC(RESET_PC)) dut (
        .clk                (clk),
        .rst                (rst),
        .PC_EN_IF           (PC_EN_IF),
        .reg_FD_stall       (reg_FD_stall),
        .reg_FD_flush       (reg_FD_flush),
        .redirect_target_ID (redirect_target_ID),
        .imem_req           (imem_req),
        .imem_addr          (imem_addr),
        .imem_ack           (imem_ack),
        .imem_rdata         (imem_rdata),
        .pc_ID              (pc_ID),
        .inst_ID            (inst_ID),
        .valid_ID           (valid_ID),
        .fetch_busy         (fetch_busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_F00F;
    endfunction

    // Memory: wcnt is the wait count of the current/next request.
    assign imem_ack   = imem_req && (wcnt == 2'd0);
    assign imem_rdata = imem_ack ? mem_word(imem_addr) : 32'hDEAD_BEEF;

    always @(posedge clk) begin
        if (rst || (imem_req && imem_ack))
            wcnt <= 2'($urandom_range(wmax, wmin));
        else if (imem_req)
            wcnt <= wcnt - 2'd1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: instructions leaving ID must follow program order from reset and redirects.
    logic [31:0] exp_pc    = RESET_PC;
    logic        prev_pend = 1'b0;
    logic [31:0] prev_addr = 32'h0;

    always @(negedge clk) begin
        if (rst) begin
            exp_pc    = RESET_PC;
            prev_pend = 1'b0;
            redir_q.delete();
        end else begin
            if (prev_pend) begin
                check("req_held", {31'b0, imem_req}, 32'd1);
                check("addr_stable", imem_addr, prev_addr);
            end
            if (imem_req)
                check("addr_align", {30'b0, imem_addr[1:0]}, 32'd0);
            if (valid_ID && !reg_FD_stall) begin
                check("id_pc", pc_ID, exp_pc);
                check("id_inst", inst_ID, mem_word(exp_pc));
                exp_pc = exp_pc + 32'd4;
                consumed++;
            end
            if (reg_FD_flush && !reg_FD_stall) begin
                tests++;
                if (redir_q.size() == 0) begin
                    fails++;
                    $display("FAIL redir_q: redirect seen with empty queue at %0t", $time);
                end else begin
                    exp_pc = redir_q.pop_front() & 32'hFFFF_FFFC;
                end
            end
            prev_pend = imem_req && !imem_ack;
            prev_addr = imem_addr;
        end
    end

    task automatic step(input logic r, input logic en, input logic st,
                        input logic fl, input logic [31:0] tgt);
        @(posedge clk);
        #1;
        rst                = r;
        PC_EN_IF           = en;
        reg_FD_stall       = st;
        reg_FD_flush       = fl;
        redirect_target_ID = tgt;
        if (fl && !st && !r)
            redir_q.push_back(tgt);
    endtask

    task automatic idle();
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        // Reset state
        wmin = 0; wmax = 0;
        repeat (3) step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        check("rst_req", {31'b0, imem_req}, 32'd0);
        check("rst_valid", {31'b0, valid_ID}, 32'd0);
        check("rst_inst", inst_ID, NOP);
        check("rst_pc", pc_ID, 32'h0);
        check("rst_busy", {31'b0, fetch_busy}, 32'd0);
        check("rst_addr", imem_addr, RESET_PC);

        // Zero-wait sequential stream
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        check("c0_req", {31'b0, imem_req}, 32'd0);
        idle();
        @(negedge clk);
        check("c1_req", {31'b0, imem_req}, 32'd1);
        check("c1_addr", imem_addr, RESET_PC);
        check("c1_valid", {31'b0, valid_ID}, 32'd0);
        for (int k = 0; k < 6; k++) begin
            idle();
            @(negedge clk);
            check("seq_valid", {31'b0, valid_ID}, 32'd1);
            check("seq_pc", pc_ID, RESET_PC + 32'(4 * k));
            check("seq_addr", imem_addr, RESET_PC + 32'(4 * (k + 1)));
        end

        // Load-use stall on an acked fetch
        step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        idle();
        @(negedge clk);
        check("hold_req", {31'b0, imem_req}, 32'd0);
        check("hold_busy", {31'b0, fetch_busy}, 32'd1);
        check("hold_pc", pc_ID, RESET_PC + 32'd24);
        idle();
        @(negedge clk);
        check("skid_pc", pc_ID, RESET_PC + 32'd28);
        check("skid_addr", imem_addr, RESET_PC + 32'd32);
        check("skid_busy", {31'b0, fetch_busy}, 32'd0);

        // Flush together with stall is ignored
        step(1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0040);
        idle();
        @(negedge clk);
        check("sf_pc", pc_ID, RESET_PC + 32'd32);
        check("sf_req", {31'b0, imem_req}, 32'd0);
        idle();
        @(negedge clk);
        check("sf_next_pc", pc_ID, RESET_PC + 32'd36);
        check("sf_next_addr", imem_addr, RESET_PC + 32'd40);

        // Redirect during a 3-wait request
        wmin = 3; wmax = 3;
        repeat (2) step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        idle();
        step(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0100);
        idle();
        @(negedge clk);
        check("drain_valid", {31'b0, valid_ID}, 32'd0);
        check("drain_busy", {31'b0, fetch_busy}, 32'd1);
        check("drain_addr", imem_addr, RESET_PC);
        idle();
        idle();
        @(negedge clk);
        check("redir_addr", imem_addr, 32'h0000_0100);
        check("redir_req", {31'b0, imem_req}, 32'd1);
        check("redir_busy", {31'b0, fetch_busy}, 32'd0);
        repeat (4) idle();
        @(negedge clk);
        check("redir_valid", {31'b0, valid_ID}, 32'd1);
        check("redir_pc", pc_ID, 32'h0000_0100);

        // Reset while draining
        step(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0300);
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        check("pre_rst_busy", {31'b0, fetch_busy}, 32'd1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        check("mrst_req", {31'b0, imem_req}, 32'd0);
        check("mrst_valid", {31'b0, valid_ID}, 32'd0);
        check("mrst_inst", inst_ID, NOP);
        check("mrst_busy", {31'b0, fetch_busy}, 32'd0);
        idle();
        @(negedge clk);
        check("mrst_addr", imem_addr, RESET_PC);
        check("mrst_req2", {31'b0, imem_req}, 32'd1);

        // Wrap and alignment of a misaligned target
        wmin = 0; wmax = 0;
        repeat (6) idle();
        step(1'b0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFE);
        idle();
        @(negedge clk);
        check("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
        idle();
        @(negedge clk);
        check("wrap_addr1", imem_addr, 32'h0000_0000);
        check("wrap_pc0", pc_ID, 32'hFFFF_FFFC);
        idle();
        @(negedge clk);
        check("wrap_pc1", pc_ID, 32'h0000_0000);

        // Randomized traffic against the program-order model
        wmin = 0; wmax = 3;
        c0 = consumed;
        for (int i = 0; i < 3000; i++) begin
            int unsigned r;
            logic [31:0] tgt;
            r   = $urandom_range(99);
            tgt = ($urandom_range(7) == 0) ? 32'hFFFF_FFFE : ($urandom & 32'h0000_FFFF);
            if (r < 15)
                step(1'b0, 1'b0, 1'b1, ($urandom_range(3) == 0), tgt);
            else if (r < 25)
                step(1'b0, 1'b1, 1'b0, 1'b1, tgt);
            else
                idle();
        end
        repeat (20) idle();
        @(negedge clk);
        check("progress", {31'b0, (consumed - c0) > 200}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
